// File: rtl/uart_rx_frame_parser.sv
// Frame parser for a UART byte stream: SOF 0xA5, LEN, LEN payload bytes, XOR checksum; payload replayed on a valid/ready port.
// Optional inter-byte timeout enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_rx_frame_parser #(
    parameter int c_maxlen         = 16,
    parameter int c_clkfreq        = 100_000_000,
    parameter int c_timeout_cycles = 100_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din_i,
    input  logic       din_valid_i,
    output logic [7:0] pl_data_o,
    output logic       pl_valid_o,
    input  logic       pl_ready_i,
    output logic       pl_last_o,
    output logic       frame_ok_o,
    output logic       frame_err_o,
    output logic [1:0] err_code_o,
    output logic       drop_tick_o
);

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_SEND} state_t;

    localparam int         c_aw       = (c_maxlen > 1) ? $clog2(c_maxlen) : 1;
    localparam int         c_depth    = 1 << c_aw;
    localparam logic [7:0] c_sof      = 8'hA5;
    localparam logic [7:0] c_maxlen_b = 8'(c_maxlen);
    localparam logic [1:0] c_err_len  = 2'b01;
    localparam logic [1:0] c_err_chk  = 2'b10;
    localparam logic [1:0] c_err_to   = 2'b11;

    if (c_maxlen < 1 || c_maxlen > 255 || c_clkfreq < 1 || c_timeout_cycles < 1) begin : g_param_check
        $error("uart_rx_frame_parser: parameter out of range");
    end

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_len;
    logic [7:0] r_chk;
    logic [7:0] r_wr_idx;
    logic [7:0] r_rd_idx;
    logic [7:0] r_buf [c_depth];
    logic       r_frame_ok;
    logic       r_frame_err;
    logic       r_drop;
    logic [1:0] r_err_code;

    logic       w_len_bad;
    logic       w_last_wr;
    logic       w_chk_match;
    logic       w_rd_last;
    logic       w_handshake;
    logic       w_timeout;
    logic       w_err_set;
    logic [1:0] w_err_code;
    logic       w_ok_set;
    logic       w_drop_set;
    logic       w_pl_valid;
    logic       w_pl_last;
    logic [7:0] w_pl_data;

    assign w_len_bad   = (din_i == 8'd0) || (din_i > c_maxlen_b);
    assign w_last_wr   = (r_wr_idx == r_len - 8'd1);
    assign w_chk_match = (din_i == r_chk);
    assign w_rd_last   = (r_rd_idx == r_len - 8'd1);
    assign w_handshake = (r_state == S_SEND) && pl_ready_i;

`ifdef UART_FRAME_TIMEOUT_EN
    logic [31:0] r_to_cnt;
    logic        w_wait_state;

    assign w_wait_state = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHK);
    assign w_timeout    = w_wait_state && !din_valid_i && (r_to_cnt == 32'(c_timeout_cycles - 1));

    // Restarts on every byte and on every state change, so entering a waiting state starts from zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (!w_wait_state || din_valid_i || (w_state_nxt != r_state)) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 32'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (din_valid_i && (din_i == c_sof)) w_state_nxt = S_LEN;
            end
            S_LEN: begin
                if (w_timeout)        w_state_nxt = S_IDLE;
                else if (din_valid_i) w_state_nxt = w_len_bad ? S_IDLE : S_PAYLOAD;
            end
            S_PAYLOAD: begin
                if (w_timeout)                     w_state_nxt = S_IDLE;
                else if (din_valid_i && w_last_wr) w_state_nxt = S_CHK;
            end
            S_CHK: begin
                if (w_timeout)        w_state_nxt = S_IDLE;
                else if (din_valid_i) w_state_nxt = w_chk_match ? S_SEND : S_IDLE;
            end
            S_SEND: begin
                if (w_handshake && w_rd_last) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_pl_valid = 1'b0;
        w_pl_last  = 1'b0;
        w_pl_data  = 8'h00;
        w_err_set  = 1'b0;
        w_err_code = 2'b00;
        w_ok_set   = 1'b0;
        w_drop_set = 1'b0;
        if (w_timeout) begin
            w_err_set  = 1'b1;
            w_err_code = c_err_to;
        end
        case (r_state)
            S_LEN: begin
                if (din_valid_i && w_len_bad) begin
                    w_err_set  = 1'b1;
                    w_err_code = c_err_len;
                end
            end
            S_CHK: begin
                if (din_valid_i && !w_chk_match) begin
                    w_err_set  = 1'b1;
                    w_err_code = c_err_chk;
                end
            end
            S_SEND: begin
                w_pl_valid = 1'b1;
                w_pl_data  = r_buf[r_rd_idx[c_aw-1:0]];
                w_pl_last  = w_rd_last;
                w_ok_set   = w_handshake && w_rd_last;
                // Bytes arriving while streaming are discarded, including during the final handshake.
                w_drop_set = din_valid_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_len    <= 8'd0;
            r_chk    <= 8'd0;
            r_wr_idx <= 8'd0;
            r_rd_idx <= 8'd0;
        end else begin
            case (r_state)
                S_LEN: begin
                    if (din_valid_i && !w_len_bad) begin
                        r_len    <= din_i;
                        r_chk    <= din_i;
                        r_wr_idx <= 8'd0;
                    end
                end
                S_PAYLOAD: begin
                    if (din_valid_i) begin
                        r_chk    <= r_chk ^ din_i;
                        r_wr_idx <= r_wr_idx + 8'd1;
                    end
                end
                S_CHK: begin
                    if (din_valid_i) r_rd_idx <= 8'd0;
                end
                S_SEND: begin
                    if (w_handshake) r_rd_idx <= r_rd_idx + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the payload buffer has no reset; it is always written before it is read.
    always_ff @(posedge clk) begin
        if ((r_state == S_PAYLOAD) && din_valid_i) begin
            r_buf[r_wr_idx[c_aw-1:0]] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_drop      <= 1'b0;
            r_err_code  <= 2'b00;
        end else begin
            r_frame_ok  <= w_ok_set;
            r_frame_err <= w_err_set;
            r_drop      <= w_drop_set;
            if (w_err_set) r_err_code <= w_err_code;
        end
    end

    assign pl_valid_o  = w_pl_valid;
    assign pl_data_o   = w_pl_data;
    assign pl_last_o   = w_pl_last;
    assign frame_ok_o  = r_frame_ok;
    assign frame_err_o = r_frame_err;
    assign drop_tick_o = r_drop;
    assign err_code_o  = r_err_code;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Scoreboard bench for uart_rx_frame_parser; expected payload bytes are queued as frames are sent.
// Define UART_FRAME_TIMEOUT_EN for both bench and RTL to exercise the timeout path.
module tb_uart_rx_frame_parser;

    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din_i;
    logic       din_valid_i;
    logic [7:0] pl_data_o;
    logic       pl_valid_o;
    logic       pl_ready_i;
    logic       pl_last_o;
    logic       frame_ok_o;
    logic       frame_err_o;
    logic [1:0] err_code_o;
    logic       drop_tick_o;

    int n_checks = 0;
    int n_errors = 0;
    int ok_cnt   = 0;
    int err_cnt  = 0;
    int drop_cnt = 0;
    logic [8:0] exp_q[$];

    uart_rx_frame_parser #(
        .c_maxlen        (16),
        .c_clkfreq       (100_000_000),
        .c_timeout_cycles(50)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_i      (din_i),
        .din_valid_i(din_valid_i),
        .pl_data_o  (pl_data_o),
        .pl_valid_o (pl_valid_o),
        .pl_ready_i (pl_ready_i),
        .pl_last_o  (pl_last_o),
        .frame_ok_o (frame_ok_o),
        .frame_err_o(frame_err_o),
        .err_code_o (err_code_o),
        .drop_tick_o(drop_tick_o)
    );

    always #5 clk = ~clk;

    // Scoreboard side: pop one expected {last,data} per accepted payload byte; also count event pulses.
    always @(negedge clk) begin
        logic [8:0] exp;
        if (frame_ok_o)  ok_cnt++;
        if (frame_err_o) err_cnt++;
        if (drop_tick_o) drop_cnt++;
        if (pl_valid_o && pl_ready_i) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL stream_unexpected: got data=%02h last=%b, expected no output", pl_data_o, pl_last_o);
            end else begin
                exp = exp_q.pop_front();
                if ({pl_last_o, pl_data_o} !== exp) begin
                    n_errors++;
                    $display("FAIL stream_byte: got last=%b data=%02h, expected last=%b data=%02h",
                             pl_last_o, pl_data_o, exp[8], exp[7:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        din_i       = b;
        din_valid_i = 1'b1;
        @(posedge clk);
        #1;
        din_valid_i = 1'b0;
        din_i       = 8'h00;
    endtask

    // Sends SOF, LEN, payload, CHK^chk_flip with UART-like gaps; returns just after the CHK byte's edge.
    task automatic send_frame(input byte_q_t pl, input logic [7:0] chk_flip, input bit push);
        logic [7:0] len;
        logic [7:0] chk;
        len = 8'(pl.size());
        chk = len;
        foreach (pl[i]) chk ^= pl[i];
        if (push) foreach (pl[i]) exp_q.push_back({(i == pl.size() - 1), pl[i]});
        send_byte(8'hA5);
        idle(2);
        send_byte(len);
        idle(2);
        foreach (pl[i]) begin
            send_byte(pl[i]);
            idle(2);
        end
        send_byte(chk ^ chk_flip);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
        idle(3);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain_timeout: got %0d bytes outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_checks++;
        if ({pl_valid_o, pl_last_o, frame_ok_o, frame_err_o, drop_tick_o, err_code_o, pl_data_o} !== 15'd0) begin
            n_errors++;
            $display("FAIL %s: got v=%b l=%b ok=%b err=%b drop=%b code=%b data=%02h, expected all zero",
                     tag, pl_valid_o, pl_last_o, frame_ok_o, frame_err_o, drop_tick_o, err_code_o, pl_data_o);
        end
    endtask

    task automatic check_delta(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        din_valid_i = 1'b0;
        din_i       = 8'h00;
        pl_ready_i  = 1'b1;
        idle(2);
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        int ok0 = ok_cnt;
        int er0 = err_cnt;
        byte_q_t pl;
        pl = {8'h11, 8'h22, 8'h33};
        send_byte(8'h11);
        idle(2);
        send_byte(8'h22);
        idle(2);
        send_frame(pl, 8'h00, 1'b1);
        n_checks++;
        if (pl_valid_o !== 1'b1 || pl_data_o !== 8'h11) begin
            n_errors++;
            $display("FAIL basic_first_latency: got v=%b data=%02h, expected v=1 data=11", pl_valid_o, pl_data_o);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (pl_valid_o !== 1'b1) begin
                n_errors++;
                $display("FAIL basic_consecutive[%0d]: got v=%b, expected 1", i, pl_valid_o);
            end
        end
        @(negedge clk);
        n_checks++;
        if (pl_valid_o !== 1'b0 || frame_ok_o !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_end: got v=%b ok=%b, expected v=0 ok=1", pl_valid_o, frame_ok_o);
        end
        wait_drain();
        check_delta("basic_ok_count", ok_cnt - ok0, 1);
        check_delta("basic_err_count", err_cnt - er0, 0);
    endtask

    task automatic test_bad_chk();
        int ok0 = ok_cnt;
        int er0 = err_cnt;
        byte_q_t pl;
        pl = {8'h11, 8'h22, 8'h33};
        send_frame(pl, 8'h07, 1'b0);
        idle(10);
        check_delta("badchk_err_count", err_cnt - er0, 1);
        check_delta("badchk_ok_count", ok_cnt - ok0, 0);
        n_checks++;
        if (err_code_o !== 2'b10) begin
            n_errors++;
            $display("FAIL badchk_code: got %b, expected 10", err_code_o);
        end
    endtask

    task automatic test_bad_len();
        int ok0 = ok_cnt;
        int er0 = err_cnt;
        byte_q_t pl;
        send_byte(8'hA5);
        idle(2);
        send_byte(8'h00);
        idle(3);
        check_delta("len0_err_count", err_cnt - er0, 1);
        n_checks++;
        if (err_code_o !== 2'b01) begin
            n_errors++;
            $display("FAIL len0_code: got %b, expected 01", err_code_o);
        end
        send_byte(8'hA5);
        idle(2);
        send_byte(8'h11);
        idle(3);
        check_delta("len17_err_count", err_cnt - er0, 2);
        n_checks++;
        if (err_code_o !== 2'b01) begin
            n_errors++;
            $display("FAIL len17_code: got %b, expected 01", err_code_o);
        end
        pl = {8'h5A, 8'hC3};
        send_frame(pl, 8'h00, 1'b1);
        wait_drain();
        check_delta("badlen_recover_ok", ok_cnt - ok0, 1);
    endtask

    task automatic test_backpressure();
        int ok0 = ok_cnt;
        int dr0 = drop_cnt;
        byte_q_t pl;
        pl = {8'h11, 8'h22, 8'h33};
        pl_ready_i = 1'b0;
        send_frame(pl, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                din_i       = 8'hA5;
                din_valid_i = 1'b1;
            end
            @(negedge clk);
            n_checks++;
            if (pl_valid_o !== 1'b1 || pl_data_o !== 8'h11 || pl_last_o !== 1'b0) begin
                n_errors++;
                $display("FAIL stall_hold[%0d]: got v=%b data=%02h last=%b, expected v=1 data=11 last=0",
                         i, pl_valid_o, pl_data_o, pl_last_o);
            end
            @(posedge clk);
            #1;
            din_valid_i = 1'b0;
        end
        pl_ready_i = 1'b1;
        wait_drain();
        check_delta("stall_drop_count", drop_cnt - dr0, 1);
        check_delta("stall_ok_count", ok_cnt - ok0, 1);
    endtask

    task automatic test_a5_in_payload();
        int ok0 = ok_cnt;
        int er0 = err_cnt;
        byte_q_t pl;
        pl = {8'hA5, 8'h11};
        send_frame(pl, 8'h00, 1'b1);
        wait_drain();
        check_delta("a5payload_ok", ok_cnt - ok0, 1);
        check_delta("a5payload_err", err_cnt - er0, 0);
    endtask

    task automatic test_back_to_back();
        int ok0 = ok_cnt;
        int er0 = err_cnt;
        int dr0 = drop_cnt;
        byte_q_t pl;
        pl = {};
        for (int i = 0; i < 16; i++) pl.push_back(8'($urandom_range(0, 255)));
        send_frame(pl, 8'h00, 1'b1);
        wait_drain();
        pl = {8'h7E};
        send_frame(pl, 8'h00, 1'b1);
        // Byte arriving in the same cycle as the single (last) byte handshake.
        din_i       = 8'hA5;
        din_valid_i = 1'b1;
        @(posedge clk);
        #1;
        din_valid_i = 1'b0;
        wait_drain();
        pl = {8'h55};
        send_frame(pl, 8'h00, 1'b1);
        wait_drain();
        check_delta("b2b_ok_count", ok_cnt - ok0, 3);
        check_delta("b2b_err_count", err_cnt - er0, 0);
        check_delta("b2b_last_drop", drop_cnt - dr0, 1);
    endtask

    task automatic test_reset_midframe();
        int ok0 = ok_cnt;
        int er0 = err_cnt;
        byte_q_t pl;
        send_byte(8'hA5);
        idle(2);
        send_byte(8'h02);
        idle(2);
        send_byte(8'h11);
        idle(1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_outputs("midframe_reset");
        idle(5);
        pl_ready_i = 1'b0;
        pl = {8'h11, 8'h22, 8'h33};
        send_frame(pl, 8'h00, 1'b0);
        idle(1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_outputs("midstream_reset");
        pl_ready_i = 1'b1;
        idle(5);
        check_delta("reset_ok_count", ok_cnt - ok0, 0);
        check_delta("reset_err_count", err_cnt - er0, 0);
        pl = {8'h7E};
        send_frame(pl, 8'h00, 1'b1);
        n_checks++;
        if (pl_valid_o !== 1'b1 || pl_last_o !== 1'b1 || pl_data_o !== 8'h7E) begin
            n_errors++;
            $display("FAIL reset_recover: got v=%b last=%b data=%02h, expected v=1 last=1 data=7E",
                     pl_valid_o, pl_last_o, pl_data_o);
        end
        wait_drain();
        check_delta("reset_recover_ok", ok_cnt - ok0, 1);
    endtask

    task automatic test_timeout();
        int ok0 = ok_cnt;
        int er0 = err_cnt;
`ifdef UART_FRAME_TIMEOUT_EN
        int n = 0;
        bit seen = 1'b0;
        send_byte(8'hA5);
        idle(2);
        send_byte(8'h02);
        idle(2);
        send_byte(8'h11);
        while (!seen && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (frame_err_o) seen = 1'b1;
        end
        check_delta("timeout_latency", seen ? n : -1, 50);
        n_checks++;
        if (err_code_o !== 2'b11) begin
            n_errors++;
            $display("FAIL timeout_code: got %b, expected 11", err_code_o);
        end
        idle(3);
        check_delta("timeout_err_count", err_cnt - er0, 1);
        check_delta("timeout_ok_count", ok_cnt - ok0, 0);
`else
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b1, 8'h22});
        send_byte(8'hA5);
        idle(2);
        send_byte(8'h02);
        idle(2);
        send_byte(8'h11);
        idle(300);
        check_delta("notimeout_err_count", err_cnt - er0, 0);
        send_byte(8'h22);
        idle(2);
        send_byte(8'h02 ^ 8'h11 ^ 8'h22);
        wait_drain();
        check_delta("notimeout_ok_count", ok_cnt - ok0, 1);
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_chk();
        test_bad_len();
        test_backpressure();
        test_a5_in_payload();
        test_back_to_back();
        test_reset_midframe();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_parser.md
UART_RX_FRAME_PARSER -- requirements
Module: uart_rx_frame_parser

Interface
REQ-001 Parameter c_maxlen, default 16: maximum payload length in bytes, range 1..255.
REQ-002 Parameter c_clkfreq, default 100_000_000: clock frequency in Hz.
REQ-003 Parameter c_timeout_cycles, default 100_000: maximum number of idle clocks allowed between bytes inside a frame.
REQ-004 clk  in  1  the single clock; all logic is on the rising edge.
REQ-005 rst_n  in  1  reset, synchronous and active-low.
REQ-006 din_i  in  8  received byte, connected to the UART receiver data output.
REQ-007 din_valid_i  in  1  one-cycle tick marking din_i valid, connected to the receiver done tick.
REQ-008 pl_data_o  out  8  payload byte being streamed out.
REQ-009 pl_valid_o  out  1  pl_data_o is valid.
REQ-010 pl_ready_i  in  1  downstream accepts pl_data_o.
REQ-011 pl_last_o  out  1  marks the final payload byte of the frame.
REQ-012 frame_ok_o  out  1  one-cycle tick after the last payload byte is accepted.
REQ-013 frame_err_o  out  1  one-cycle tick when a frame is rejected.
REQ-014 err_code_o  out  2  reason for the most recent error: 01 length, 10 checksum, 11 timeout; held until the next error.
REQ-015 drop_tick_o  out  1  one-cycle tick when an input byte is discarded while the block is streaming.

Function
REQ-016 Frame format, in order: SOF byte 0xA5, LEN byte, LEN payload bytes, CHK byte.
- CHK = XOR of LEN and all payload bytes.
REQ-017 The FSM SHALL use states S_IDLE, S_LEN, S_PAYLOAD, S_CHK and S_SEND.
REQ-018 S_IDLE: din_valid_i with din_i==0xA5 -> S_LEN; any other byte is ignored with no flag.
REQ-019 S_LEN: LEN==0 or LEN>c_maxlen -> frame_err_o pulse, err_code_o=01, -> S_IDLE.
- Otherwise: store LEN, initialise the running checksum to LEN, clear the write index, -> S_PAYLOAD.
REQ-020 S_PAYLOAD: each byte is written to buffer[index], XORed into the checksum, and the index increments.
- The byte at index LEN-1 -> S_CHK.
REQ-021 S_CHK: on the received byte, compare it with the running checksum.
- Mismatch -> frame_err_o pulse, err_code_o=10, -> S_IDLE.
- Match -> S_SEND with read index 0.
REQ-022 S_SEND: pl_valid_o=1 and pl_data_o=buffer[read index].
- pl_last_o=1 when read index==LEN-1.
- pl_data_o SHALL remain stable while pl_valid_o=1 and pl_ready_i=0.
REQ-023 On pl_valid_o&&pl_ready_i the read index increments.
- On the last byte: pl_valid_o falls the next cycle, frame_ok_o pulses the next cycle, -> S_IDLE.
REQ-024 First pl_valid_o assertion SHALL occur exactly 1 clock after the CHK byte's din_valid_i cycle.
REQ-025 din_valid_i during S_SEND: the byte is discarded, drop_tick_o pulses, and the FSM is unaffected.
REQ-026 A second 0xA5 received inside S_PAYLOAD SHALL be treated as payload data, not as a resync.
REQ-027 din_valid_i in the same cycle as the last-byte handshake SHALL be dropped with drop_tick_o.
REQ-028 frame_ok_o, frame_err_o and drop_tick_o are each high for exactly one cycle per event.

Reset
REQ-029 rst_n=0 at a rising edge SHALL, in the next cycle, give:
- state S_IDLE;
- all indices, counters and checksum 0;
- pl_valid_o, pl_last_o, frame_ok_o, frame_err_o, drop_tick_o = 0;
- pl_data_o=0x00, err_code_o=00.
REQ-030 Reset mid-frame or mid-stream SHALL abandon the frame with no ok or error pulse; buffer contents need not be cleared.

Configuration
REQ-031 Macro UART_FRAME_TIMEOUT_EN, when defined, SHALL enable an inter-byte timeout in S_LEN, S_PAYLOAD and S_CHK.
- The counter clears on every din_valid_i and on entry to these states.
- Reaching c_timeout_cycles -> frame_err_o pulse, err_code_o=11, -> S_IDLE.
REQ-032 With UART_FRAME_TIMEOUT_EN undefined, no timeout counter SHALL exist and these states SHALL wait indefinitely; code 11 never occurs.

Verification
REQ-033 Bytes A5 03 11 22 33 03, pl_ready_i=1 -> outputs 11, 22, 33 on consecutive cycles; pl_last_o with 33; one frame_ok_o.
REQ-034 Same frame with CHK=04 -> no pl_valid_o; frame_err_o once; err_code_o=10.
REQ-035 A5 00 and A5 11 (c_maxlen=16) -> frame_err_o each; err_code_o=01; next valid frame still parses.
REQ-036 pl_ready_i low for 5 cycles after the first byte plus a byte injected during S_SEND -> pl_data_o=11 held stable; one drop_tick_o; output sequence unchanged.
REQ-037 UART_FRAME_TIMEOUT_EN defined, c_timeout_cycles=50, A5 02 11 then silence -> frame_err_o 50 clocks after the 11 byte; err_code_o=11.
REQ-038 rst_n low for 1 cycle after A5 02 11 -> all outputs at reset values; next A5 01 7E 7F -> output 7E with pl_last_o and frame_ok_o.
